// File: rtl/elm_pkg.sv
// Shared definitions for the ELM P-sample sequencer: default widths,
// watchdog limits and the sequencer state encoding.
package elm_pkg;

    localparam int IDX_W_DEF   = 9;
    localparam int TMO_W_DEF   = 8;
    localparam int TMO_MAX_DEF = 200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_ADV   = 3'd5,
        ST_FIN   = 3'd6
    } seq_state_e;

    // Every state other than IDLE belongs to an active pass.
    function automatic logic state_is_busy(input seq_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/elm_wait_timer.sv
// Clear/enable up-counter with a terminal-count flag, used as the
// calc_done watchdog. The owner clears it before the count can wrap.
module elm_wait_timer #(
    parameter int W  = 8,
    parameter int TC = 199
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count_r;

    // Count while enabled; a clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == W'(TC));

endmodule

// File: rtl/elm_p_sequencer.sv
// Control side of the P-sample index counter: for every sample it starts
// the hidden-layer compute unit, waits for its done pulse, writes the
// result at P_index and advances the counter until stop is seen.
module elm_p_sequencer
    import elm_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [IDX_W-1:0] P_index,
    input  logic             stop,
    output logic             en_P,
    output logic             rst_P,
    output logic             calc_start,
    input  logic             calc_done,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_addr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    seq_state_e       state_r;
    logic [IDX_W-1:0] wr_addr_r;
    logic             err_r;
    logic             wd_clr_s;
    logic             wd_en_s;
    logic             wd_tc_s;

    // The watchdog restarts on every START and only advances in WAIT.
    assign wd_clr_s = (state_r == ST_START);
    assign wd_en_s  = (state_r == ST_WAIT);

    elm_wait_timer #(
        .W  (TMO_W),
        .TC (TMO_MAX - 1)
    ) u_wd (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr_s),
        .en  (wd_en_s),
        .tc  (wd_tc_s)
    );

    // Sequencer state, captured write address and sticky timeout flag.
    // Abort outranks calc_done, stop and the watchdog in any active state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wr_addr_r <= '0;
            err_r     <= 1'b0;
        end else if (abort && state_is_busy(state_r)) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        state_r <= ST_CLR;
                        err_r   <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLR:   state_r <= ST_START;
                ST_START: state_r <= ST_WAIT;
                ST_WAIT: begin
                    if (calc_done) begin
                        state_r   <= ST_WRITE;
                        wr_addr_r <= P_index;
                    end else if (wd_tc_s) begin
                        state_r <= ST_IDLE;
                        err_r   <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WRITE: state_r <= stop ? ST_FIN : ST_ADV;
                ST_ADV:   state_r <= ST_START;
                ST_FIN:   state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        en_P       = 1'b0;
        rst_P      = 1'b0;
        calc_start = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (state_r)
            ST_CLR:   rst_P      = 1'b1;
            ST_START: calc_start = 1'b1;
            ST_WRITE: wr_en      = 1'b1;
            ST_ADV:   en_P       = 1'b1;
            ST_FIN: begin
                done  = 1'b1;
                rst_P = 1'b1;
            end
            default: begin
                en_P = 1'b0;
            end
        endcase
    end

    assign busy    = state_is_busy(state_r);
    assign wr_addr = wr_addr_r;
    assign err     = err_r;

endmodule

// File: tb/tb_elm_p_sequencer.sv
// Directed bench for elm_p_sequencer with a 0..3 sample counter and a
// compute-unit model of programmable latency.
module tb_elm_p_sequencer;

    localparam int IDX_W = 9;
    localparam int LAST  = 3;

    logic             clk = 1'b0;
    logic             rst, go, abort, stop;
    logic             en_P, rst_P, calc_start, calc_done;
    logic             wr_en, busy, done, err;
    logic [IDX_W-1:0] P_index, wr_addr;

    int checks   = 0;
    int failures = 0;

    elm_p_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .abort      (abort),
        .P_index    (P_index),
        .stop       (stop),
        .en_P       (en_P),
        .rst_P      (rst_P),
        .calc_start (calc_start),
        .calc_done  (calc_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Sample counter (counts only on rst_P/en_P; own init reset)
    logic ctr_rst;
    always @(posedge clk) begin
        if (ctr_rst)     P_index <= '0;
        else if (rst_P)  P_index <= '0;
        else if (en_P)   P_index <= P_index + 1'b1;
    end
    assign stop = (P_index == IDX_W'(LAST));

    // Compute unit model: done lat cycles after the START cycle
    logic             model_en, skip_en, manual_done;
    logic [IDX_W-1:0] skip_idx;
    int               lat;
    int               pend;
    always @(posedge clk) begin
        if (ctr_rst)          pend <= 0;
        else if (calc_start)  pend <= lat;
        else if (pend != 0)   pend <= pend - 1;
    end
    assign calc_done = manual_done |
                       (model_en && (pend == 1) && !(skip_en && (P_index == skip_idx)));

    // Event monitor, sampled on the falling edge
    int cyc = 0, wr_total = 0, done_total = 0, done_cyc = 0, last_wr_cyc = 0;
    int start_total = 0, enp_total = 0, rstp_total = 0, busy_total = 0, overlap_total = 0;
    logic [IDX_W-1:0] wr_log [0:255];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (wr_en) begin
                wr_log[wr_total % 256] <= wr_addr;
                wr_total    <= wr_total + 1;
                last_wr_cyc <= cyc;
            end
            if (done) begin
                done_total <= done_total + 1;
                done_cyc   <= cyc;
            end
            if (calc_start)    start_total   <= start_total + 1;
            if (en_P)          enp_total     <= enp_total + 1;
            if (rst_P)         rstp_total    <= rstp_total + 1;
            if (busy)          busy_total    <= busy_total + 1;
            if (en_P && rst_P) overlap_total <= overlap_total + 1;
        end
    end

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ctr_rst = 1'b1; go = 1'b0; abort = 1'b0;
        model_en = 1'b1; skip_en = 1'b0; skip_idx = '0; manual_done = 1'b0; lat = 2;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, wr_en, en_P, rst_P, calc_start} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outs: got %b required 0000000",
                     {busy, done, err, wr_en, en_P, rst_P, calc_start});
        end
        checks++;
        if (wr_addr !== 9'd0) begin
            failures++; $display("FAIL reset_wr_addr: got %0d required 0", wr_addr);
        end
        rst = 1'b0; ctr_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_full_pass();
        int b_wr, b_done, b_start, b_enp, b_rstp, b_busy;
        bit ok;
        b_wr = wr_total; b_done = done_total; b_start = start_total;
        b_enp = enp_total; b_rstp = rstp_total; b_busy = busy_total;
        lat = 2; model_en = 1'b1;
        go = 1'b1; @(negedge clk); go = 1'b0;
        checks++;
        if (rst_P !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL pass_clr: rst_P=%b busy=%b required 1 1", rst_P, busy);
        end
        @(negedge clk);
        checks++;
        if (rst_P !== 1'b0 || calc_start !== 1'b1) begin
            failures++; $display("FAIL pass_start: rst_P=%b calc_start=%b required 0 1", rst_P, calc_start);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL pass_timeout: busy stuck high, required idle"); end
        checks++;
        if (start_total - b_start !== 4) begin
            failures++; $display("FAIL pass_starts: got %0d required 4", start_total - b_start);
        end
        checks++;
        if (wr_total - b_wr !== 4) begin
            failures++; $display("FAIL pass_writes: got %0d required 4", wr_total - b_wr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_log[(b_wr + i) % 256] !== IDX_W'(i)) begin
                failures++;
                $display("FAIL pass_addr%0d: got %0d required %0d", i, wr_log[(b_wr + i) % 256], i);
            end
        end
        checks++;
        if (enp_total - b_enp !== 3) begin
            failures++; $display("FAIL pass_enp: got %0d required 3", enp_total - b_enp);
        end
        checks++;
        if (rstp_total - b_rstp !== 2) begin
            failures++; $display("FAIL pass_rstp: got %0d required 2 (CLR+FIN)", rstp_total - b_rstp);
        end
        checks++;
        if (done_total - b_done !== 1) begin
            failures++; $display("FAIL pass_done: got %0d required 1", done_total - b_done);
        end
        checks++;
        if (done_cyc !== last_wr_cyc + 1) begin
            failures++; $display("FAIL pass_done_pos: done cyc %0d required %0d", done_cyc, last_wr_cyc + 1);
        end
        checks++;
        if (busy_total - b_busy !== 21) begin
            failures++; $display("FAIL pass_len: got %0d required 21", busy_total - b_busy);
        end
        checks++;
        if (overlap_total !== 0) begin
            failures++; $display("FAIL pass_overlap: en_P&rst_P cycles %0d required 0", overlap_total);
        end
    endtask

    task automatic test_go_while_busy();
        int b_wr, b_done, b_busy;
        bit ok;
        b_wr = wr_total; b_done = done_total; b_busy = busy_total;
        go = 1'b1; @(negedge clk); go = 1'b0;
        repeat (6) @(negedge clk);
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok || wr_total - b_wr !== 4 || done_total - b_done !== 1 || busy_total - b_busy !== 21) begin
            failures++;
            $display("FAIL gobusy_pass: ok=%0d writes=%0d done=%0d len=%0d required 1 4 1 21",
                     ok, wr_total - b_wr, done_total - b_done, busy_total - b_busy);
        end
        b_wr = wr_total; b_done = done_total;
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok || wr_total - b_wr !== 4 || wr_log[b_wr % 256] !== 9'd0 || done_total - b_done !== 1) begin
            failures++;
            $display("FAIL gobusy_second: ok=%0d writes=%0d first=%0d done=%0d required 1 4 0 1",
                     ok, wr_total - b_wr, wr_log[b_wr % 256], done_total - b_done);
        end
    endtask

    task automatic test_early_done();
        int  b_wr, b_done, b_busy;
        bit  ok, seen;
        b_wr = wr_total; b_done = done_total; b_busy = busy_total;
        model_en = 1'b0;
        go = 1'b1; @(negedge clk); go = 1'b0;
        for (int s = 0; s < 4; s++) begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (calc_start) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            if (!seen) break;
            manual_done = 1'b1;     // START cycle, then first WAIT cycle
            @(negedge clk);
            @(negedge clk);
            manual_done = 1'b0;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL early_start_seen: calc_start missing, required 4 starts"); end
        wait_idle(100, ok);
        model_en = 1'b1;
        checks++;
        if (!ok || busy_total - b_busy !== 17) begin
            failures++; $display("FAIL early_len: ok=%0d len=%0d required 1 17", ok, busy_total - b_busy);
        end
        checks++;
        if (wr_total - b_wr !== 4 || done_total - b_done !== 1) begin
            failures++;
            $display("FAIL early_writes: writes=%0d done=%0d required 4 1", wr_total - b_wr, done_total - b_done);
        end
    endtask

    task automatic test_timeout();
        int b_wr, b_done, b_busy;
        bit ok;
        b_wr = wr_total; b_done = done_total; b_busy = busy_total;
        lat = 2; skip_en = 1'b1; skip_idx = 9'd2;
        go = 1'b1; @(negedge clk); go = 1'b0;
        wait_idle(400, ok);
        checks++;
        if (!ok || busy_total - b_busy !== 212) begin
            failures++; $display("FAIL tmo_len: ok=%0d len=%0d required 1 212", ok, busy_total - b_busy);
        end
        checks++;
        if (err !== 1'b1 || done_total - b_done !== 0 || wr_total - b_wr !== 2) begin
            failures++;
            $display("FAIL tmo_result: err=%b done=%0d writes=%0d required 1 0 2",
                     err, done_total - b_done, wr_total - b_wr);
        end
        skip_en = 1'b0;
        b_done = done_total;
        go = 1'b1; @(negedge clk); go = 1'b0;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_clear: err=%b required 0", err); end
        wait_idle(100, ok);
        checks++;
        if (!ok || done_total - b_done !== 1) begin
            failures++; $display("FAIL tmo_recover: ok=%0d done=%0d required 1 1", ok, done_total - b_done);
        end
    endtask

    task automatic test_abort();
        int b_wr, b_done, n;
        bit ok;
        b_wr = wr_total; b_done = done_total; n = 0;
        lat = 2;
        go = 1'b1; @(negedge clk); go = 1'b0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            @(negedge clk);
            if (calc_start) n++;
        end
        @(negedge clk);                 // first WAIT cycle of sample 1
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (n !== 2 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_idle: starts=%0d busy=%b required 2 0", n, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_total - b_wr !== 1 || done_total - b_done !== 0) begin
            failures++;
            $display("FAIL abort_effects: writes=%0d done=%0d required 1 0", wr_total - b_wr, done_total - b_done);
        end
        b_wr = wr_total; b_done = done_total;
        go = 1'b1; @(negedge clk); go = 1'b0;
        checks++;
        if (rst_P !== 1'b1) begin failures++; $display("FAIL abort_restart_clr: rst_P=%b required 1", rst_P); end
        wait_idle(100, ok);
        checks++;
        if (!ok || wr_total - b_wr !== 4 || wr_log[b_wr % 256] !== 9'd0 || done_total - b_done !== 1) begin
            failures++;
            $display("FAIL abort_restart: ok=%0d writes=%0d first=%0d done=%0d required 1 4 0 1",
                     ok, wr_total - b_wr, wr_log[b_wr % 256], done_total - b_done);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 1'b0;
        lat = 2;
        go = 1'b1; @(negedge clk); go = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_P) begin seen = 1'b1; break; end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!seen || {busy, en_P, rst_P, calc_start, wr_en, done, err} !== 7'b0 || wr_addr !== 9'd0) begin
            failures++;
            $display("FAIL arst_outs: seen=%0d outs=%b wr_addr=%0d required 1 0000000 0",
                     seen, {busy, en_P, rst_P, calc_start, wr_en, done, err}, wr_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (P_index !== 9'd0) begin
            failures++; $display("FAIL arst_no_enp: P_index=%0d required 0", P_index);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL arst_idle: busy=%b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_go_while_busy();
        test_early_done();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
